hash_loader: RTL and testbench
==============================

# hash_loader

Receive-side stage between the UART byte receiver and the cracking controller. Parses a host load command from the received byte stream and assembles 16-byte NTLM target hashes into 128-bit words. Writes each word into the on-chip hash SRAM, then reports completion and the hash count. Also detects the idle-time progress-request byte that the controller answers over the transmit path.

## Interface
Parameters:
- ADDR_W, 10, SRAM address width
- BASE_ADDR, 0, SRAM address of hash 0
- MAX_HASHES, 64, largest accepted hash count (64 x 128 = 8192 bits)
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles while a load is open

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte, valid when data_ready=1
- data_ready  in  1  one-cycle strobe per received byte, clk domain
- framing_error  in  1  receiver framing error, sampled with data_ready
- overrun_error  in  1  receiver overrun, sampled every cycle
- write_enable  out  1  SRAM write strobe, one cycle per hash
- address  out  ADDR_W  SRAM write address
- write_data  out  128  assembled hash, byte 0 in bits [127:120]
- hash_count  out  7  hashes written in current/last load
- busy  out  1  high while a load is in progress
- load_done  out  1  one-cycle pulse on successful load completion
- load_error  out  1  sticky error flag
- progress_request_byte_detected  out  1  one-cycle pulse

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Command bytes (IDLE only): 0xA5 = LOAD, 0x3F = PROGRESS. All other bytes are ignored in IDLE.
- Load format: 0xA5, count byte N, then N x 16 hash bytes, MSB first.
- IDLE:
  - 0xA5 → GET_COUNT. Clear hash_count, load_error, byte index and hash index; set busy.
  - 0x3F → pulse progress_request_byte_detected.
- GET_COUNT:
  - N in 1..MAX_HASHES → latch N, go to GET_BYTES.
  - N=0 or N>MAX_HASHES → ERROR.
- GET_BYTES:
  - Each strobe shifts rx_data into a 128-bit assembly register; the 4-bit byte index increments.
  - When byte index wraps 15→0, the assembly register is snapshotted into write_data.
  - 0x3F and 0xA5 are plain data in this state.
- Write pipeline: a write runs one cycle after the 16th byte's strobe and does not stall reception.
  - write_enable=1 with address = BASE_ADDR + hash index.
  - On that cycle, hash index and hash_count increment.
- Completion: on the write of hash N, go to DONE.
- DONE: pulse load_done for one cycle, clear busy, return to IDLE.
- ERROR: set load_error, clear busy, return to IDLE next cycle.
  - Already-written SRAM words are kept; hash_count holds the number written.
  - load_error stays set until the next accepted 0xA5.
- Error causes while busy:
  - framing_error sampled with a strobe; that byte is discarded.
  - overrun_error=1 on any cycle.
  - Timeout counter reaching TIMEOUT_CYC. The counter is 20 bits, reloads on every strobe and runs only while busy.
- Errors outside a load are ignored.

## Timing
- Reset values:
  - write_enable=0, address=BASE_ADDR, write_data=0, hash_count=0.
  - busy=0, load_done=0, load_error=0, progress_request_byte_detected=0.
  - State = IDLE, all counters 0.
- All outputs are registered.
- progress_request_byte_detected asserts the cycle after the 0x3F strobe.
- busy rises the cycle after the 0xA5 strobe.
- write_enable asserts the cycle after the 16th byte strobe of each hash. address and write_data are valid in that same cycle and held until the next write.
- load_done asserts the cycle after the final write_enable; busy falls in the same cycle.
- Back-to-back strobes, at most one per cycle, are accepted without loss in every state.
- A strobe in the DONE or ERROR cycle is treated as an IDLE byte next cycle; it is not dropped.
- Reset mid-load aborts immediately with no further write_enable. The SRAM is not cleared.

## Test plan
- Reset check: assert rst mid-cycle → all outputs at reset values asynchronously. After release, state is IDLE.
- Single hash:
  - Stimulus: 0xA5, 0x01, then bytes 0x00..0x0F.
  - Required: one write_enable at address 0 with write_data=128'h000102030405060708090A0B0C0D0E0F.
  - Required: load_done the next cycle and hash_count=1.
- Back-to-back stream: 0xA5, 0x03, then 48 bytes on consecutive cycles → writes at addresses 0, 1, 2, each one cycle after bytes 16, 32, 48; load_done once; hash_count=3.
- Bad count: 0xA5, 0x00 → load_error=1, busy=0, no write. Likewise 0xA5, 0x41 (65) gives the same response.
- Abort during load:
  - 0xA5, 0x02, 20 bytes, then framing_error with a strobe → load_error=1 and hash_count=1.
  - Repeat with a timeout of TIMEOUT_CYC silent cycles → same result.
- Progress byte:
  - 0x3F in IDLE → one-cycle pulse the next cycle.
  - 0x3F as a hash data byte → no pulse; the byte appears in write_data.

Source files
------------

// File: rtl/hash_loader_if.sv
// Byte-receive and hash-SRAM-write signal bundle for hash_loader.
// The slave side is the loader; the master side is the UART receiver and SRAM together.
interface hash_loader_if #(parameter int ADDR_W = 10) ();
   logic [7:0]        rx_data;
   logic              data_ready;
   logic              framing_error;
   logic              overrun_error;
   logic              write_enable;
   logic [ADDR_W-1:0] address;
   logic [127:0]      write_data;
   logic [6:0]        hash_count;
   logic              busy;
   logic              load_done;
   logic              load_error;
   logic              progress_request_byte_detected;

   modport slave (
      input  rx_data, data_ready, framing_error, overrun_error,
      output write_enable, address, write_data, hash_count, busy,
             load_done, load_error, progress_request_byte_detected
   );

   modport master (
      output rx_data, data_ready, framing_error, overrun_error,
      input  write_enable, address, write_data, hash_count, busy,
             load_done, load_error, progress_request_byte_detected
   );
endinterface

// File: rtl/hash_loader.sv
// Parses the host load command and assembles the 16-byte hashes into 128-bit SRAM writes.
// It also flags the idle-time progress-request byte.
module hash_loader #(
   parameter int ADDR_W      = 10,
   parameter int BASE_ADDR   = 0,
   parameter int MAX_HASHES  = 64,
   parameter int TIMEOUT_CYC = 1000000
) (
   input logic            clk,
   input logic            rst,
   hash_loader_if.slave   bus
);
   localparam logic [7:0]        CMD_LOAD = 8'hA5;
   localparam logic [7:0]        CMD_PROG = 8'h3F;
   localparam logic [7:0]        MAXN     = 8'(MAX_HASHES);
   localparam logic [19:0]       TMO      = 20'(TIMEOUT_CYC);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {IDLE, GET_COUNT, GET_BYTES, DONE, ERROR} state_t;

   state_t       state;
   logic [127:0] asm_q;
   logic [3:0]   byte_idx;
   logic [6:0]   n_hashes;
   logic [19:0]  tmo;
   logic [7:0]   pend;
   logic         pend_vld;

   logic         in_load;
   logic [7:0]   cmd;
   logic         cnt_ok;
   logic         abort;
   logic [127:0] asm_nxt;

   // A byte caught in the DONE/ERROR cycle waits in pend and is handled as the next IDLE byte.
   assign in_load = (state == GET_COUNT) || (state == GET_BYTES);
   assign cmd     = pend_vld ? pend : bus.rx_data;
   assign cnt_ok  = !bus.framing_error && (bus.rx_data != 8'd0) && (bus.rx_data <= MAXN);
   assign asm_nxt = {asm_q[119:0], bus.rx_data};
   assign abort   = in_load && (bus.overrun_error || (tmo == TMO) ||
                    (bus.data_ready && ((state == GET_BYTES) ? bus.framing_error : !cnt_ok)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         asm_q        <= '0;
         byte_idx     <= '0;
         n_hashes     <= '0;
         tmo          <= '0;
         pend         <= '0;
         pend_vld     <= 1'b0;
         bus.write_enable <= 1'b0;
         bus.address      <= BASE;
         bus.write_data   <= '0;
         bus.hash_count   <= '0;
         bus.busy         <= 1'b0;
         bus.load_done    <= 1'b0;
         bus.load_error   <= 1'b0;
         bus.progress_request_byte_detected <= 1'b0;
      end else begin
         bus.write_enable <= 1'b0;
         bus.load_done    <= 1'b0;
         bus.progress_request_byte_detected <= 1'b0;
         tmo <= (in_load && !bus.data_ready) ? tmo + 20'd1 : '0;

         if (abort) begin
            state          <= ERROR;
            bus.load_error <= 1'b1;
            bus.busy       <= 1'b0;
         end else begin
            case (state)
               IDLE: if (pend_vld || bus.data_ready) begin
                  pend_vld <= 1'b0;
                  if (cmd == CMD_LOAD) begin
                     bus.hash_count <= '0;
                     bus.load_error <= 1'b0;
                     bus.busy       <= 1'b1;
                     byte_idx       <= '0;
                     state          <= GET_COUNT;
                     // Stashed LOAD plus a fresh strobe: the fresh byte is the count.
                     if (pend_vld && bus.data_ready) begin
                        if (cnt_ok) begin
                           n_hashes <= bus.rx_data[6:0];
                           state    <= GET_BYTES;
                        end else begin
                           state          <= ERROR;
                           bus.load_error <= 1'b1;
                           bus.busy       <= 1'b0;
                        end
                     end
                  end else begin
                     if (cmd == CMD_PROG) bus.progress_request_byte_detected <= 1'b1;
                     if (pend_vld && bus.data_ready) begin
                        pend     <= bus.rx_data;
                        pend_vld <= 1'b1;
                     end
                  end
               end
               GET_COUNT: if (bus.data_ready) begin
                  n_hashes <= bus.rx_data[6:0];
                  state    <= GET_BYTES;
               end
               GET_BYTES: if (bus.data_ready) begin
                  asm_q    <= asm_nxt;
                  byte_idx <= byte_idx + 4'd1;
                  if (byte_idx == 4'hF) begin
                     bus.write_enable <= 1'b1;
                     bus.write_data   <= asm_nxt;
                     bus.address      <= BASE + ADDR_W'(bus.hash_count);
                     bus.hash_count   <= bus.hash_count + 7'd1;
                     if (bus.hash_count + 7'd1 == n_hashes) state <= DONE;
                  end
               end
               DONE: begin
                  bus.load_done <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
                  if (bus.data_ready) begin
                     pend     <= bus.rx_data;
                     pend_vld <= 1'b1;
                  end
               end
               ERROR: begin
                  state <= IDLE;
                  if (bus.data_ready) begin
                     pend     <= bus.rx_data;
                     pend_vld <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hash_loader.sv
// Directed bench for hash_loader: a table of load scenarios plus hand-written corner sequences.
module tb_hash_loader;
   localparam int TO = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   last_cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   hash_loader_if #(.ADDR_W(10)) bus ();

   hash_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_HASHES(64), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int           wr_addr[$];
   logic [127:0] wr_data[$];
   int           wr_cyc[$];
   int           done_cyc[$];
   int           prog_cyc[$];

   always @(negedge clk) if (!rst) begin
      if (bus.write_enable) begin
         wr_addr.push_back(int'(bus.address));
         wr_data.push_back(bus.write_data);
         wr_cyc.push_back(cyc);
      end
      if (bus.load_done) done_cyc.push_back(cyc);
      if (bus.progress_request_byte_detected) prog_cyc.push_back(cyc);
   end

   task automatic clear_logs();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      done_cyc.delete(); prog_cyc.delete();
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic put(input logic [7:0] b, input logic fe);
      bus.rx_data       = b;
      bus.data_ready    = 1'b1;
      bus.framing_error = fe;
      @(negedge clk);
      last_cyc          = cyc;
      bus.data_ready    = 1'b0;
      bus.framing_error = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [127:0] hash_val(input int off, input int h);
      logic [127:0] r = '0;
      for (int k = 0; k < 16; k++) r = {r[119:0], 8'(off + 16*h + k)};
      return r;
   endfunction

   typedef struct {
      string name;
      int    n;       // count byte sent after 0xA5
      int    nbytes;  // data bytes sent
      int    off;     // data byte i = (off + i) mod 256
      int    fe_at;   // byte index carrying framing_error, -1 for none
      int    exp_wr;
      int    exp_err;
      int    exp_done;
   } vec_t;

   vec_t vt[7];

   task automatic run_vec(input vec_t v);
      int exp_wc[$];
      clear_logs();
      put(8'hA5, 1'b0);
      put(8'(v.n), 1'b0);
      for (int i = 0; i < v.nbytes; i++) begin
         put(8'(v.off + i), i == v.fe_at);
         if ((i % 16) == 15 && i != v.fe_at) exp_wc.push_back(last_cyc);
      end
      idle(6);
      chki({v.name, " writes"}, wr_addr.size(), v.exp_wr);
      for (int h = 0; h < v.exp_wr && h < wr_addr.size(); h++) begin
         chki({v.name, " addr"}, wr_addr[h], h);
         chkv({v.name, " data"}, wr_data[h], hash_val(v.off, h));
         chki({v.name, " wr_cycle"}, wr_cyc[h], exp_wc[h]);
      end
      chki({v.name, " done_pulses"}, done_cyc.size(), v.exp_done);
      if (v.exp_done != 0 && done_cyc.size() > 0 && wr_cyc.size() > 0)
         chki({v.name, " done_cycle"}, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
      chki({v.name, " load_error"}, int'(bus.load_error), v.exp_err);
      chki({v.name, " busy"}, int'(bus.busy), 0);
      chki({v.name, " hash_count"}, int'(bus.hash_count), v.exp_wr);
      chki({v.name, " prog_pulses"}, prog_cyc.size(), 0);
   endtask

   initial begin
      int s;
      vt[0] = '{"single",      1,   16, 8'h00, -1,  1, 0, 1};
      vt[1] = '{"three",       3,   48, 8'h40, -1,  3, 0, 1};
      vt[2] = '{"count0",      0,    0, 0,     -1,  0, 1, 0};
      vt[3] = '{"count65",     65,   0, 0,     -1,  0, 1, 0};
      vt[4] = '{"framing",     2,   21, 8'h80, 20,  1, 1, 0};
      vt[5] = '{"prog_data",   1,   16, 8'h30, -1,  1, 0, 1};
      vt[6] = '{"max64",       64, 1024, 8'h00, -1, 64, 0, 1};

      bus.rx_data = '0; bus.data_ready = 1'b0;
      bus.framing_error = 1'b0; bus.overrun_error = 1'b0;
      idle(3);
      chki("rst we",    int'(bus.write_enable), 0);
      chki("rst addr",  int'(bus.address), 0);
      chkv("rst wdata", bus.write_data, '0);
      chki("rst hc",    int'(bus.hash_count), 0);
      chki("rst busy",  int'(bus.busy), 0);
      chki("rst done",  int'(bus.load_done), 0);
      chki("rst err",   int'(bus.load_error), 0);
      chki("rst prog",  int'(bus.progress_request_byte_detected), 0);
      rst = 1'b0;
      idle(2);

      // Progress byte in IDLE: single pulse in the cycle following the strobe.
      clear_logs();
      put(8'h3F, 1'b0);
      s = last_cyc;
      idle(4);
      chki("prog count", prog_cyc.size(), 1);
      if (prog_cyc.size() > 0) chki("prog cycle", prog_cyc[0], s);

      for (int i = 0; i < 7; i++) run_vec(vt[i]);

      // An accepted LOAD clears the sticky error and raises busy next cycle.
      put(8'hA5, 1'b0);
      chki("rearm busy", int'(bus.busy), 1);
      chki("rearm err",  int'(bus.load_error), 0);
      put(8'h00, 1'b0);
      idle(3);
      chki("rearm bad err", int'(bus.load_error), 1);

      // Inter-byte timeout.
      clear_logs();
      put(8'hA5, 1'b0); put(8'h02, 1'b0);
      for (int i = 0; i < 20; i++) put(8'(i), 1'b0);
      s = last_cyc;
      idle(35);
      chki("tmo busy before", int'(bus.busy), 1);
      idle(10);
      chki("tmo busy", int'(bus.busy), 0);
      chki("tmo err",  int'(bus.load_error), 1);
      chki("tmo hc",   int'(bus.hash_count), 1);
      chki("tmo writes", wr_addr.size(), 1);

      // Strobe in the DONE cycle is held and handled as an IDLE byte one cycle late.
      clear_logs();
      put(8'hA5, 1'b0); put(8'h01, 1'b0);
      for (int i = 0; i < 16; i++) put(8'(8'h10 + i), 1'b0);
      put(8'h3F, 1'b0);
      s = last_cyc;
      idle(4);
      chki("done3f prog", prog_cyc.size(), 1);
      if (prog_cyc.size() > 0) chki("done3f cycle", prog_cyc[0], s + 1);

      // LOAD arriving in the DONE cycle starts a second load without losing its count.
      clear_logs();
      put(8'hA5, 1'b0); put(8'h01, 1'b0);
      for (int i = 0; i < 16; i++) put(8'(i), 1'b0);
      put(8'hA5, 1'b0); put(8'h01, 1'b0);
      for (int i = 0; i < 16; i++) put(8'(8'h20 + i), 1'b0);
      idle(5);
      chki("b2b writes", wr_addr.size(), 2);
      chki("b2b dones",  done_cyc.size(), 2);
      if (wr_data.size() == 2) chkv("b2b data1", wr_data[1], hash_val(8'h20, 0));
      chki("b2b hc",  int'(bus.hash_count), 1);
      chki("b2b err", int'(bus.load_error), 0);

      // Overrun outside a load is ignored; inside a load it aborts.
      bus.overrun_error = 1'b1; idle(1); bus.overrun_error = 1'b0; idle(2);
      chki("ovr idle err", int'(bus.load_error), 0);
      put(8'hA5, 1'b0); put(8'h01, 1'b0);
      for (int i = 0; i < 5; i++) put(8'(i), 1'b0);
      bus.overrun_error = 1'b1; idle(1); bus.overrun_error = 1'b0; idle(3);
      chki("ovr load err",  int'(bus.load_error), 1);
      chki("ovr load busy", int'(bus.busy), 0);
      chki("ovr load hc",   int'(bus.hash_count), 0);

      // Asynchronous reset mid-load, then the leftover bytes must not cause writes.
      put(8'hA5, 1'b0); put(8'h02, 1'b0);
      for (int i = 0; i < 20; i++) put(8'(8'h50 + i), 1'b0);
      #2 rst = 1'b1;
      #1;
      chki("mid rst addr",  int'(bus.address), 0);
      chkv("mid rst wdata", bus.write_data, '0);
      chki("mid rst hc",    int'(bus.hash_count), 0);
      chki("mid rst busy",  int'(bus.busy), 0);
      idle(2);
      rst = 1'b0;
      clear_logs();
      for (int i = 0; i < 12; i++) put(8'h01, 1'b0);
      idle(4);
      chki("post rst writes", wr_addr.size(), 0);
      chki("post rst busy",   int'(bus.busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
